// File: rtl/puc_pkg.sv
// Shared types and constants for the accumulator CPU run controller.
package puc_pkg;

    typedef enum logic [1:0] {
        HALTED     = 2'd0,
        RUNNING    = 2'd1,
        STEPPING   = 2'd2,
        RESTARTING = 2'd3
    } run_state_e;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_RUN     = 3'd1,
        CMD_HALT    = 3'd2,
        CMD_STEP    = 3'd3,
        CMD_WRITE   = 3'd4,
        CMD_SETBP   = 3'd5,
        CMD_CLRBP   = 3'd6,
        CMD_RESTART = 3'd7
    } host_cmd_e;

    localparam logic [3:0] OP_RESET4   = 4'd4;
    localparam logic [3:0] OP_CALL8    = 4'd8;
    localparam logic [3:0] OP_EXIT9    = 4'd9;
    localparam logic [4:0] STACK_DEPTH = 5'd16;

endpackage

// File: rtl/run_controller_if.sv
// Host command channel and instruction-memory write port of the run controller.
interface run_controller_if #(
    parameter int PC_WIDTH          = 8,
    parameter int INSTRUCTION_WIDTH = 20
);
    logic                         hostValid;
    logic                         hostReady;
    logic [2:0]                   hostCmd;
    logic [PC_WIDTH-1:0]          hostAddr;
    logic [INSTRUCTION_WIDTH-1:0] hostData;
    logic                         memWrite;
    logic [PC_WIDTH-1:0]          memAddr;
    logic [INSTRUCTION_WIDTH-1:0] memData;

    modport master (
        output hostValid, hostCmd, hostAddr, hostData,
        input  hostReady, memWrite, memAddr, memData
    );

    modport slave (
        input  hostValid, hostCmd, hostAddr, hostData,
        output hostReady, memWrite, memAddr, memData
    );
endinterface

// File: rtl/run_controller_stack_guard.sv
// Return-stack depth tracker: flags CALL past the stack depth or EXIT at depth 0.
module stack_guard
    import puc_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    isResetN,
    input  run_state_e              state,
    input  logic                    exec,
    input  logic [OPCODE_WIDTH-1:0] opCode,
    output logic                    guard_stop,
    output logic                    stack_fault
);
    logic [4:0] depth_r;
    logic       fault_r;
    logic       call_s;
    logic       exit_s;
    logic       bad_s;

    assign call_s      = (opCode == OPCODE_WIDTH'(OP_CALL8));
    assign exit_s      = (opCode == OPCODE_WIDTH'(OP_EXIT9));
    assign bad_s       = (call_s && (depth_r >= STACK_DEPTH)) || (exit_s && (depth_r == 5'd0));
    assign guard_stop  = bad_s && (state == RUNNING);
    assign stack_fault = fault_r;

    // Depth follows executed instructions and saturates at both ends
    always_ff @(posedge clock) begin
        if (!isResetN) begin
            depth_r <= 5'd0;
            fault_r <= 1'b0;
        end else begin
            if (state == RESTARTING) begin
                depth_r <= 5'd0;
            end else if (exec) begin
                if (opCode == OPCODE_WIDTH'(OP_RESET4)) begin
                    depth_r <= 5'd0;
                end else if (call_s && (depth_r != 5'd31)) begin
                    depth_r <= depth_r + 5'd1;
                end else if (exit_s && (depth_r != 5'd0)) begin
                    depth_r <= depth_r - 5'd1;
                end else begin
                    depth_r <= depth_r;
                end
            end else begin
                depth_r <= depth_r;
            end
            if (bad_s && ((state == RUNNING) || (state == STEPPING))) begin
                fault_r <= 1'b1;
            end else begin
                fault_r <= fault_r;
            end
        end
    end
endmodule

// File: rtl/run_controller.sv
// Run/halt/step/restart sequencer with pc breakpoint and program-load arbitration.
// Optional return-stack guard enabled by RUN_CONTROLLER_STACK_GUARD_EN.
module run_controller
    import puc_pkg::*;
#(
    parameter int PC_WIDTH          = 8,
    parameter int INSTRUCTION_WIDTH = 20,
    parameter int OPCODE_WIDTH      = 4
) (
    input  logic                    clock,
    input  logic                    isResetN,
    run_controller_if.slave         host,
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic [OPCODE_WIDTH-1:0] opCode,
    output logic                    cpuEnable,
    output logic                    cpuReset,
    output logic [1:0]              runState,
    output logic                    bpHit,
    output logic                    errSticky,
    output logic                    stackFault
);
    run_state_e                   state_r, state_next_s;
    logic                         bp_en_r, ignore_bp_r, bp_hit_r, bp_hit_next_s, err_r;
    logic [PC_WIDTH-1:0]          bp_addr_r, mem_addr_r;
    logic [INSTRUCTION_WIDTH-1:0] mem_data_r;
    logic                         mem_write_r;
    logic                         ready_s, accept_s, write_ok_s;
    logic                         bp_stop_s, guard_stop_s, stop_s, stack_fault_s;

    assign ready_s    = isResetN && ((state_r == HALTED) || (state_r == RUNNING));
    assign accept_s   = host.hostValid && ready_s;
    assign write_ok_s = accept_s && (host.hostCmd == CMD_WRITE) && (state_r == HALTED);
    // The ignore flag lets a resumed run execute the instruction sitting on the breakpoint
    assign bp_stop_s  = (state_r == RUNNING) && bp_en_r && (pc == bp_addr_r) && !ignore_bp_r;
    assign stop_s     = bp_stop_s || guard_stop_s;

`ifdef RUN_CONTROLLER_STACK_GUARD_EN
    logic exec_s;
    assign exec_s = isResetN && (((state_r == RUNNING) && !stop_s) || (state_r == STEPPING));

    stack_guard #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_stack_guard (
        .clock       (clock),
        .isResetN    (isResetN),
        .state       (state_r),
        .exec        (exec_s),
        .opCode      (opCode),
        .guard_stop  (guard_stop_s),
        .stack_fault (stack_fault_s)
    );
`else
    logic unused_opcode_s;
    assign unused_opcode_s = ^opCode;
    assign guard_stop_s    = 1'b0;
    assign stack_fault_s   = 1'b0;
`endif

    // Next-state decode; a state-changing command outranks a stop in the same cycle
    always_comb begin
        state_next_s  = state_r;
        bp_hit_next_s = 1'b0;
        case (state_r)
            HALTED: begin
                if (accept_s) begin
                    case (host.hostCmd)
                        CMD_RUN:     state_next_s = RUNNING;
                        CMD_STEP:    state_next_s = STEPPING;
                        CMD_RESTART: state_next_s = RESTARTING;
                        default:     state_next_s = HALTED;
                    endcase
                end else begin
                    state_next_s = HALTED;
                end
            end
            RUNNING: begin
                if (accept_s && ((host.hostCmd == CMD_HALT) || (host.hostCmd == CMD_STEP))) begin
                    state_next_s = HALTED;
                end else if (accept_s && (host.hostCmd == CMD_RESTART)) begin
                    state_next_s = RESTARTING;
                end else if (stop_s) begin
                    state_next_s  = HALTED;
                    bp_hit_next_s = bp_stop_s;
                end else begin
                    state_next_s = RUNNING;
                end
            end
            default: state_next_s = HALTED;
        endcase
    end

    // State, breakpoint, memory write port and sticky error registers
    always_ff @(posedge clock) begin
        if (!isResetN) begin
            state_r     <= HALTED;
            bp_en_r     <= 1'b0;
            bp_addr_r   <= {PC_WIDTH{1'b0}};
            ignore_bp_r <= 1'b0;
            bp_hit_r    <= 1'b0;
            err_r       <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= {PC_WIDTH{1'b0}};
            mem_data_r  <= {INSTRUCTION_WIDTH{1'b0}};
        end else begin
            state_r     <= state_next_s;
            bp_hit_r    <= bp_hit_next_s;
            ignore_bp_r <= accept_s && (host.hostCmd == CMD_RUN);
            mem_write_r <= write_ok_s;
            if (write_ok_s) begin
                mem_addr_r <= host.hostAddr;
                mem_data_r <= host.hostData;
            end else begin
                mem_addr_r <= mem_addr_r;
                mem_data_r <= mem_data_r;
            end
            if (accept_s && (host.hostCmd == CMD_SETBP)) begin
                bp_addr_r <= host.hostAddr;
                bp_en_r   <= 1'b1;
            end else if (accept_s && (host.hostCmd == CMD_CLRBP)) begin
                bp_en_r   <= 1'b0;
            end else begin
                bp_en_r   <= bp_en_r;
            end
            if (accept_s && (host.hostCmd == CMD_WRITE) && (state_r == RUNNING)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Reset forces the CPU into its own synchronous reset and silences the host side
    assign cpuEnable      = !isResetN || ((state_r == RUNNING) && !stop_s) ||
                            (state_r == STEPPING) || (state_r == RESTARTING);
    assign cpuReset       = !isResetN || (state_r == RESTARTING);
    assign runState       = state_r;
    assign bpHit          = isResetN && bp_hit_r;
    assign errSticky      = isResetN && err_r;
    assign stackFault     = isResetN && stack_fault_s;
    assign host.hostReady = ready_s;
    assign host.memWrite  = isResetN && mem_write_r;
    assign host.memAddr   = mem_addr_r;
    assign host.memData   = mem_data_r;
endmodule

// File: doc/run_controller.md
# run_controller

Run-control and program-load sequencer for the accumulator CPU. It owns the CPU clock enable and the CPU reset, and arbitrates the instruction memory write port for a host/debug interface. It provides run, halt, single-step, restart and a single pc breakpoint. It sits between the host command interface and the CPU/MEMORY pair, which it drives through `cpuEnable`, `cpuReset` and the memory write port.

## Interface

Parameters:
- `PC_WIDTH`, default 8: program counter and memory address width.
- `INSTRUCTION_WIDTH`, default 20: instruction word width.
- `OPCODE_WIDTH`, default 4: opcode field width.

Ports (clock and reset first):
- `clock`  in  1: single clock; all state changes on its rising edge.
- `isResetN`  in  1: reset, synchronous, active-low.
- `hostValid`  in  1: host command valid.
- `hostReady`  out  1: controller accepts a command this cycle.
- `hostCmd`  in  3: 0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 WRITE, 5 SETBP, 6 CLRBP, 7 RESTART.
- `hostAddr`  in  PC_WIDTH: address for WRITE and SETBP.
- `hostData`  in  INSTRUCTION_WIDTH: instruction word for WRITE.
- `pc`  in  PC_WIDTH: current CPU pc.
- `opCode`  in  OPCODE_WIDTH: opcode of the instruction at `pc`.
- `cpuEnable`  out  1: CPU clock enable; the CPU executes one instruction per cycle in which this is high.
- `cpuReset`  out  1: active-high reset to the CPU.
- `memWrite`, `memAddr`, `memData`  out  1 / PC_WIDTH / INSTRUCTION_WIDTH: instruction memory write port.
- `runState`  out  2: 0 HALTED, 1 RUNNING, 2 STEPPING, 3 RESTARTING.
- `bpHit`  out  1: one-cycle pulse on a breakpoint stop.
- `errSticky`  out  1: an illegal command was dropped; cleared only by reset.
- `stackFault`  out  1: sticky return-stack fault (see Configuration).

## Operation

- A command is accepted on any cycle where `hostValid && hostReady`. `hostReady` is 0 during reset, STEPPING and RESTARTING, and 1 otherwise.
- HALTED:
  - RUN → RUNNING.
  - STEP → STEPPING.
  - WRITE → one-cycle memory write.
  - SETBP → breakpoint address := `hostAddr` and breakpoint enabled.
  - CLRBP → breakpoint disabled.
  - RESTART → RESTARTING.
  - HALT and NOP have no effect.
- RUNNING:
  - HALT or STEP → HALTED.
  - WRITE → dropped and `errSticky` set.
  - SETBP and CLRBP take effect immediately.
  - RUN and NOP have no effect.
  - RESTART → RESTARTING.
- STEPPING lasts exactly one cycle, then → HALTED.
- RESTARTING lasts exactly one cycle, then → HALTED. It clears the guard depth counter and preserves the breakpoint.
- Breakpoint: a match is `pc == bpAddr` with the breakpoint enabled. On a match while RUNNING:
  - `cpuEnable` is 0 that cycle, so the instruction at `bpAddr` is not executed.
  - The state goes → HALTED and `bpHit` pulses.
  - On the first RUNNING cycle after any RUN, the match is ignored, so resuming from a breakpoint executes that instruction.
  - STEP always ignores the breakpoint.
- Output decode:
  - `cpuEnable = (RUNNING && !stop) || STEPPING || RESTARTING`.
  - `cpuReset = RESTARTING`.
  - `stop` is the breakpoint stop or the guard stop.

## Timing

- While `isResetN` is low:
  - `cpuEnable`=1 and `cpuReset`=1, so the CPU's synchronous reset takes effect.
  - `hostReady`=0, `memWrite`=0, `bpHit`=0, `errSticky`=0, `stackFault`=0.
  - Breakpoint disabled, breakpoint address 0, guard depth 0.
  - The first cycle after release is HALTED.
- Command accepted at cycle N → new state visible at N+1, with `cpuEnable` valid combinationally in N+1.
- STEP at N: `cpuEnable`=1 in N+1 only; HALTED again at N+2.
- WRITE at N: `memWrite`=1 with registered `memAddr`/`memData` in N+1 only.
- Breakpoint: `bpHit` is high in the cycle after the match cycle; `runState` reads HALTED in that same cycle.
- A command accepted in the same cycle as a breakpoint or guard match: the command wins, except RUN, which cannot re-arm the breakpoint ignore-cycle until N+1.
- Reset asserted mid-STEP or mid-RESTART aborts it; the reset values apply in the next cycle.

## Configuration

`RUN_CONTROLLER_STACK_GUARD_EN`:
- Defined:
  - A 5-bit call depth is tracked over enabled cycles. opCode 8 (CALL) increments it, 9 (EXIT) decrements it, 4 (RESET) clears it.
  - A CALL at depth 16 or an EXIT at depth 0 while RUNNING is a guard stop: `cpuEnable`=0, → HALTED, `stackFault` set.
  - While STEPPING the same instruction sets `stackFault` but still executes.
- Undefined: no depth counter, `stackFault` tied 0, guard stop always false.

## Structure

- Shared package `puc_pkg`:
  - run-state enum (HALTED/RUNNING/STEPPING/RESTARTING)
  - host command encodings
  - opcode constants CALL8, EXIT9, RESET4
  - return-stack depth constant 16
- One sub-module `stack_guard`: depth counter and fault detection, instantiated only under the macro.

## Test plan

- Reset, WRITE addr 3 data 0x12345, WRITE addr 4 → `memWrite` pulses at N+1 with matching addr/data; `cpuEnable`=0 throughout.
- SETBP 5, RUN with the CPU counting from pc 0 → `cpuEnable` is high for pcs 0–4 and low at pc 5; `bpHit` pulses once; HALTED.
- From that breakpoint: RUN → pc 5 executes (`cpuEnable`=1 at pc 5), and the run continues to pc 6 and beyond.
- Three STEPs from HALTED → exactly 3 `cpuEnable` cycles; `hostReady`=0 in each step cycle.
- WRITE while RUNNING → no `memWrite`, `errSticky`=1. Then RESTART → `cpuReset`=`cpuEnable`=1 for one cycle, then HALTED.
- With `RUN_CONTROLLER_STACK_GUARD_EN` defined, 17 nested CALLs → 16 execute; halt at the 17th with `stackFault`=1. An EXIT at depth 0 also faults.
